// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: FP32 field constants, lane-id width helper and the two multiplier halves
// (product front end / normalise-round back end) shared by the MULT_SCHED_MID_REG_EN split.
package mult_sched_pkg;
   localparam int EXP_BIAS = 127;
   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int PROD_W   = 2 * (MAN_W + 1);
   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [PROD_W-1:0] prod;
   } mid_t;
   function automatic int id_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
   function automatic mid_t mul_front(input logic [31:0] a, input logic [31:0] b);
      mid_t m;
      m.sign = a[31] ^ b[31];
      m.exp  = a[30:23] + b[30:23];
      m.prod = PROD_W'({|a[30:23], a[22:0]}) * PROD_W'({|b[30:23], b[22:0]});
      return m;
   endfunction
   // Exponent arithmetic wraps to 8 bits; there is deliberately no NaN/Inf/overflow handling.
   function automatic logic [31:0] mul_back(input mid_t m);
      logic [PROD_W-1:0] pn;
      pn = m.prod[PROD_W-1] ? m.prod : m.prod << 1;
      return {m.sign,
              m.exp + EXP_W'(m.prod[PROD_W-1]) - EXP_W'(EXP_BIAS),
              pn[PROD_W-2 -: MAN_W] + MAN_W'(pn[MAN_W] & |pn[MAN_W-1:0])};
   endfunction
endpackage

// File: rtl/fp32_mul_core.sv
// fp32_mul_core: FP32 multiply; with MULT_SCHED_MID_REG_EN the 48-bit product is registered
// (held while i_hold) ahead of normalise/round.
module fp32_mul_core
   import mult_sched_pkg::*;
(
`ifdef MULT_SCHED_MID_REG_EN
   input  logic        clk,
   input  logic        i_hold,
`endif
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_p
);
`ifdef MULT_SCHED_MID_REG_EN
   mid_t r_mid;
   always_ff @(posedge clk)
      if (!i_hold) r_mid <= mul_front(i_a, i_b);
   assign o_p = mul_back(r_mid);
`else
   assign o_p = mul_back(mul_front(i_a, i_b));
`endif
endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin share of one FP32 multiplier among N lanes with tag passthrough
// and global stall; MULT_SCHED_MID_REG_EN adds a pipeline register inside the multiplier.
module mult_scheduler
   import mult_sched_pkg::*;
#(
   parameter  int N          = 4,
   parameter  int value_size = 32,
   parameter  int TAG_W      = 16,
   localparam int ID_W       = id_w(N)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N-1:0]            req_valid,
   output logic [N-1:0]            req_ready,
   input  logic [N*value_size-1:0] req_val,
   input  logic [N*value_size-1:0] req_vec_val,
   input  logic [N*TAG_W-1:0]      req_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [value_size-1:0]   out_pprod,
   output logic [ID_W-1:0]         out_src,
   output logic [TAG_W-1:0]        out_tag,
   output logic                    busy
);
   typedef struct packed {
      logic                  valid;
      logic [ID_W-1:0]       src;
      logic [TAG_W-1:0]      tag;
      logic [value_size-1:0] a;
      logic [value_size-1:0] b;
   } stage_t;
   stage_t                r_s1;
   logic [ID_W-1:0]       r_ptr, w_gnt, w_last_src;
   logic                  w_stall, w_found, w_hs, w_last_valid;
   logic [TAG_W-1:0]      w_last_tag;
   logic [value_size-1:0] w_prod;
   assign w_stall = out_valid & ~out_ready;
   // Rotating priority: first valid lane at or after the pointer.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      for (int i = 0; i < N; i++) begin
         if (!w_found && req_valid[(int'(r_ptr) + i) % N]) begin
            w_found = 1'b1;
            w_gnt   = ID_W'((int'(r_ptr) + i) % N);
         end
      end
   end
   assign w_hs      = w_found & ~w_stall & ~rst;
   assign req_ready = w_hs ? N'(1) << w_gnt : '0;
   fp32_mul_core u_mul (
`ifdef MULT_SCHED_MID_REG_EN
      .clk    (clk),
      .i_hold (w_stall),
`endif
      .i_a    (r_s1.a),
      .i_b    (r_s1.b),
      .o_p    (w_prod)
   );
`ifdef MULT_SCHED_MID_REG_EN
   logic             r_vm;
   logic [ID_W-1:0]  r_mid_src;
   logic [TAG_W-1:0] r_mid_tag;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vm      <= 1'b0;
         r_mid_src <= '0;
         r_mid_tag <= '0;
      end else if (!w_stall) begin
         r_vm      <= r_s1.valid;
         r_mid_src <= r_s1.src;
         r_mid_tag <= r_s1.tag;
      end
   end
   assign w_last_valid = r_vm;
   assign w_last_src   = r_mid_src;
   assign w_last_tag   = r_mid_tag;
   assign busy         = r_s1.valid | r_vm | out_valid;
`else
   assign w_last_valid = r_s1.valid;
   assign w_last_src   = r_s1.src;
   assign w_last_tag   = r_s1.tag;
   assign busy         = r_s1.valid | out_valid;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1      <= '0;
         r_ptr     <= '0;
         out_valid <= 1'b0;
         out_pprod <= '0;
         out_src   <= '0;
         out_tag   <= '0;
      end else if (!w_stall) begin
         r_s1.valid <= w_hs;
         if (w_hs) begin
            r_s1.src <= w_gnt;
            r_s1.tag <= req_tag[int'(w_gnt)*TAG_W +: TAG_W];
            r_s1.a   <= req_val[int'(w_gnt)*value_size +: value_size];
            r_s1.b   <= req_vec_val[int'(w_gnt)*value_size +: value_size];
            r_ptr    <= (w_gnt == ID_W'(N-1)) ? '0 : w_gnt + 1'b1;
         end
         out_valid <= w_last_valid;
         out_pprod <= w_prod;
         out_src   <= w_last_src;
         out_tag   <= w_last_tag;
      end
   end
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: directed vectors plus a scoreboarded random run for mult_scheduler.
module tb_mult_scheduler;
   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid, req_ready;
   logic [127:0] req_val, req_vec_val;
   logic [63:0]  req_tag;
   logic         out_valid, out_ready, busy;
   logic [31:0]  out_pprod;
   logic [1:0]   out_src;
   logic [15:0]  out_tag;
   int           n_vec = 0, n_bad = 0, popped = 0;
   logic [31:0]  q_p[$];
   logic [15:0]  q_t[$];
   logic [1:0]   q_s[$];
   logic [31:0]  exp_p[4] = '{32'h40C00000, 32'h40100000, 32'hC1200000, 32'h3F800000};
   logic [31:0]  op_a[4]  = '{32'h40000000, 32'h3FC00000, 32'hC0200000, 32'h3F800000};
   logic [31:0]  op_b[4]  = '{32'h40400000, 32'h3FC00000, 32'h40800000, 32'h3F800000};

   mult_scheduler #(.N(4), .value_size(32), .TAG_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_val(req_val), .req_vec_val(req_vec_val), .req_tag(req_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_pprod(out_pprod),
      .out_src(out_src), .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b, input logic [15:0] t);
      req_val[i*32 +: 32]     = a;
      req_vec_val[i*32 +: 32] = b;
      req_tag[i*16 +: 16]     = t;
   endtask

   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [22:0] m;
      logic [7:0]  e;
      logic        n;
      p = {24'd0, |a[30:23], a[22:0]} * {24'd0, |b[30:23], b[22:0]};
      n = p[47];
      m = n ? p[46:24] + {22'd0, p[23] & |p[22:0]} : p[45:23] + {22'd0, p[22] & |p[21:0]};
      e = a[30:23] + b[30:23] + {7'd0, n} - 8'd127;
      return {a[31] ^ b[31], e, m};
   endfunction

   task automatic sample_out();
      if (out_valid && out_ready) begin
         if (q_p.size() == 0) check("rnd_spurious", 64'd1, 64'd0);
         else begin
            check("rnd_out", {14'd0, out_src, out_tag, out_pprod}, {14'd0, q_s[0], q_t[0], q_p[0]});
            void'(q_p.pop_front());
            void'(q_t.pop_front());
            void'(q_s.pop_front());
            popped++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
      req_val = '0; req_vec_val = '0; req_tag = '0;
      repeat (3) step();
      check("rst_state", {busy, out_valid, req_ready, out_pprod, out_src, out_tag}, '0);
      rst = 1'b0; req_valid = '0;
      step();

      // single lane 0: 2 x 3
      set_lane(0, 32'h40000000, 32'h40400000, 16'h0005);
      req_valid = 4'b0001;
      #1 check("t1_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      check("t1_s1", {busy, out_valid}, 2'b10);
      step();
      check("t1_out", {out_valid, out_src, out_tag, out_pprod}, {1'b1, 2'd0, 16'h0005, 32'h40C00000});
      step();
      check("t1_idle", {busy, out_valid}, 2'b00);

      // all lanes continuously, from ptr 0
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 4; i++) set_lane(i, op_a[i], op_b[i], 16'h0100 + 16'(i));
      req_valid = 4'hF;
      for (int c = 0; c < 10; c++) begin
         if (c == 8) req_valid = '0;
         #1;
         if (c < 8) check("t2_grant", req_ready, 4'b0001 << (c % 4));
         if (c >= 2) check("t2_out", {out_valid, out_src, out_tag, out_pprod},
                           {1'b1, 2'((c-2) % 4), 16'h0100 + 16'((c-2) % 4), exp_p[(c-2) % 4]});
         step();
      end

      // back-pressure with lane 2 at the output
      set_lane(2, 32'h3FC00000, 32'h3FC00000, 16'h0022);
      set_lane(1, 32'h40000000, 32'h40400000, 16'h0011);
      req_valid = 4'b0100; out_ready = 1'b0;
      #1 check("t3_grant", req_ready, 4'b0100);
      step();
      req_valid = 4'b0010;
      step();
      req_valid = 4'b1001;
      for (int c = 0; c < 5; c++) begin
         #1 check("t3_hold", {req_ready, out_valid, out_src, out_tag, out_pprod},
                  {4'b0000, 1'b1, 2'd2, 16'h0022, 32'h40100000});
         step();
      end
      req_valid = '0; out_ready = 1'b1;
      #1 check("t3_release", {out_valid, out_tag}, {1'b1, 16'h0022});
      step();
      check("t3_next", {out_valid, out_src, out_tag, out_pprod}, {1'b1, 2'd1, 16'h0011, 32'h40C00000});
      step();
      check("t3_idle", {busy, out_valid}, 2'b00);

      // lanes 1 and 3 with ptr at 2
      req_valid = 4'b1010;
      #1 check("t4_first", req_ready, 4'b1000);
      step();
      check("t4_second", req_ready, 4'b0010);
      step();
      req_valid = '0;
      check("t4_out3", {out_valid, out_src}, {1'b1, 2'd3});
      step();
      check("t4_out1", {out_valid, out_src}, {1'b1, 2'd1});
      step();

      // reset with two entries in flight
      req_valid = 4'b0011;
      step(); step();
      req_valid = '0; rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5_flush", {busy, out_valid}, 2'b00);
      req_valid = 4'b1010;
      #1 check("t5_ptr", req_ready, 4'b0010);
      req_valid = '0;
      for (int c = 0; c < 3; c++) begin
         step();
         check("t5_quiet", {busy, out_valid}, 2'b00);
      end

      // random traffic against the scoreboard
      begin
         int cyc = 0;
         while (popped < 10000 && cyc < 60000) begin
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) set_lane(i, $urandom, $urandom, 16'($urandom));
            #1;
            check("rnd_ready", {60'd0, (req_ready & ~req_valid) | (out_valid && !out_ready ? req_ready : 4'd0)}, 64'd0);
            for (int i = 0; i < 4; i++)
               if (req_valid[i] && req_ready[i]) begin
                  q_p.push_back(fmul(req_val[i*32 +: 32], req_vec_val[i*32 +: 32]));
                  q_t.push_back(req_tag[i*16 +: 16]);
                  q_s.push_back(2'(i));
               end
            sample_out();
            step();
            cyc++;
         end
         req_valid = '0; out_ready = 1'b1;
         for (int c = 0; c < 5; c++) begin
            #1 sample_out();
            step();
         end
         check("rnd_count", 64'(popped >= 10000), 64'd1);
         check("rnd_drain", {busy, 31'd0, 32'(q_p.size())}, 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
